serial_subtractor: RTL



---
 rtl/serial_subtractor_if.sv | 42 ++++
 rtl/serial_subtractor.sv | 105 ++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start,
        output a,
        output b,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  busy,
        input  done,
        input  diff,
        input  borrow
    );

    modport slave (
        input  start,
        input  a,
        input  b,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output busy,
        output done,
        output diff,
        output borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d_bit;
    logic             br_next;
    logic             last_bit;
    logic [WIDTH-1:0] sr_next;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    always_comb begin
        d_bit      = sa[0] ^ sb[0] ^ br;
        br_next    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sr_next    = {d_bit, sr[WIDTH-1:1]};
        last_bit   = (cnt == CW'(WIDTH - 1));
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Datapath and registered outputs; diff/borrow only move on the final shift edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.diff   <= '0;
            bus.borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            bus.ovf    <= 1'b0;
`endif
        end else begin
            bus.busy <= (state_next != IDLE);
            bus.done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        br  <= 1'b0;
                        cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    br <= br_next;
                    sr <= sr_next;
                    if (last_bit) begin
                        bus.diff   <= sr_next;
                        bus.borrow <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        bus.ovf    <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
